// File: rtl/lock_in_sequencer_if.sv
// ADC sample stream, lock-in engine handshake and decimated result bus
// seen by the lock-in sequencer.
interface lock_in_sequencer_if #(
  parameter int NUM_BITS = 24
);
  logic                adc_valid_i;
  logic [NUM_BITS-1:0] adc_ch1_i;
  logic [NUM_BITS-1:0] adc_ch2_i;
  logic [NUM_BITS-1:0] lia_ch1_o;
  logic [NUM_BITS-1:0] lia_ch2_o;
  logic                lia_tick_o;
  logic                lia_reset_o;
  logic [NUM_BITS-1:0] lia_x_i;
  logic [NUM_BITS-1:0] lia_y_i;
  logic                lia_done_i;
  logic [NUM_BITS-1:0] x_o;
  logic [NUM_BITS-1:0] y_o;
  logic                valid_o;

  // Sequencer side
  modport slave (
    input  adc_valid_i, adc_ch1_i, adc_ch2_i, lia_x_i, lia_y_i, lia_done_i,
    output lia_ch1_o, lia_ch2_o, lia_tick_o, lia_reset_o, x_o, y_o, valid_o
  );

  // ADC front end, engine and consumer side
  modport master (
    output adc_valid_i, adc_ch1_i, adc_ch2_i, lia_x_i, lia_y_i, lia_done_i,
    input  lia_ch1_o, lia_ch2_o, lia_tick_o, lia_reset_o, x_o, y_o, valid_o
  );
endinterface

// File: rtl/lock_in_sequencer.sv
// Drives the shared lock-in engine from the ADC stream, decimates its X/Y
// results and flags dropped samples and hung engines.
module lock_in_sequencer #(
  parameter int NUM_BITS     = 24,
  parameter int DECIM_W      = 16,
  parameter int TIMEOUT      = 64,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [DECIM_W-1:0] decim_i,
  lock_in_sequencer_if.slave bus,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               timeout_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FLUSH, WAIT_SAMPLE, TICK, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [FL_W-1:0]     flush_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [DECIM_W-1:0]  dec_cnt;
  logic [DECIM_W:0]    dec_next;
  logic [DECIM_W:0]    decim_eff;
  logic [NUM_BITS-1:0] ch1_q, ch2_q, x_q, y_q;
  logic                tick_q, lia_reset_q, valid_q;

  logic done_ev, accept, emit, drop, timeout_hit, flush_entry;
  logic tick_nxt, lia_reset_nxt, busy_nxt;

  // Event decode; enable_i low discards everything in flight
  assign done_ev     = enable_i && (state == WAIT_DONE) && bus.lia_done_i;
  assign accept      = enable_i && bus.adc_valid_i &&
                       ((state == WAIT_SAMPLE) || done_ev);
  assign drop        = enable_i && bus.adc_valid_i && !accept &&
                       (state != WAIT_SAMPLE);
  assign timeout_hit = enable_i && (state == WAIT_DONE) && !bus.lia_done_i &&
                       (to_cnt == TO_W'(TIMEOUT - 1));
  assign dec_next    = {1'b0, dec_cnt} + {{DECIM_W{1'b0}}, 1'b1};
  assign decim_eff   = (decim_i == '0) ? {{DECIM_W{1'b0}}, 1'b1} : {1'b0, decim_i};
  assign emit        = done_ev && (dec_next >= decim_eff);
  assign flush_entry = (state_nxt == FLUSH) && (state != FLUSH);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:        state_nxt = FLUSH;
        FLUSH:       if (flush_cnt == '0) state_nxt = WAIT_SAMPLE;
        WAIT_SAMPLE: if (bus.adc_valid_i) state_nxt = TICK;
        TICK:        state_nxt = WAIT_DONE;
        WAIT_DONE: begin
          if (bus.lia_done_i) state_nxt = bus.adc_valid_i ? TICK : WAIT_SAMPLE;
          else if (timeout_hit) state_nxt = FLUSH;
        end
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered, so they are decoded from the next state
  always_comb begin
    tick_nxt      = (state_nxt == TICK);
    lia_reset_nxt = (state_nxt == IDLE) || (state_nxt == FLUSH);
    busy_nxt      = (state_nxt == TICK) || (state_nxt == WAIT_DONE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      flush_cnt   <= '0;
      to_cnt      <= '0;
      dec_cnt     <= '0;
      ch1_q       <= '0;
      ch2_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      tick_q      <= 1'b0;
      lia_reset_q <= 1'b1;
      valid_q     <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      tick_q      <= tick_nxt;
      lia_reset_q <= lia_reset_nxt;
      busy_o      <= busy_nxt;
      valid_q     <= emit;

      if (flush_entry)                            flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;

      if (state == TICK)           to_cnt <= '0;
      else if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;

      if (flush_entry)  dec_cnt <= '0;
      else if (emit)    dec_cnt <= '0;
      else if (done_ev) dec_cnt <= dec_next[DECIM_W-1:0];

      if (accept) begin
        ch1_q <= bus.adc_ch1_i;
        ch2_q <= bus.adc_ch2_i;
      end

      if (emit) begin
        x_q <= bus.lia_x_i;
        y_q <= bus.lia_y_i;
      end

      // A set event in the same cycle beats clear_i
      if (drop)         overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;

      if (timeout_hit)  timeout_o <= 1'b1;
      else if (clear_i) timeout_o <= 1'b0;
    end
  end

  assign bus.lia_ch1_o   = ch1_q;
  assign bus.lia_ch2_o   = ch2_q;
  assign bus.lia_tick_o  = tick_q;
  assign bus.lia_reset_o = lia_reset_q;
  assign bus.x_o         = x_q;
  assign bus.y_o         = y_q;
  assign bus.valid_o     = valid_q;

endmodule

// File: tb/tb_lock_in_sequencer.sv
// Directed bench for lock_in_sequencer: reset/flush, basic path, decimation,
// overrun, timeout and disable scenarios with hand-computed expectations.
module tb_lock_in_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        clear_i;
  logic [15:0] decim_i;
  logic        busy_o, overrun_o, timeout_o;
  int          checks = 0;
  int          failures = 0;

  lock_in_sequencer_if #(.NUM_BITS(24)) bus ();

  lock_in_sequencer #(
    .NUM_BITS(24), .DECIM_W(16), .TIMEOUT(64), .FLUSH_CYCLES(4)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .clear_i   (clear_i),
    .decim_i   (decim_i),
    .bus       (bus),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one sample from WAIT_SAMPLE, answer with done `lat` cycles after the
  // tick, and report what the result bus shows on the following cycle
  task automatic send_sample(input logic [23:0] c1, input logic [23:0] c2,
                             input logic [23:0] rx, input logic [23:0] ry,
                             input int lat, output logic got_valid,
                             output logic [23:0] gx, output logic [23:0] gy);
    bus.adc_valid_i = 1'b1;
    bus.adc_ch1_i   = c1;
    bus.adc_ch2_i   = c2;
    step();
    bus.adc_valid_i = 1'b0;
    for (int i = 0; i < lat; i++) step();
    bus.lia_done_i = 1'b1;
    bus.lia_x_i    = rx;
    bus.lia_y_i    = ry;
    step();
    bus.lia_done_i = 1'b0;
    got_valid = bus.valid_o;
    gx        = bus.x_o;
    gy        = bus.y_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0; decim_i = 16'd1;
    bus.adc_valid_i = 1'b0; bus.adc_ch1_i = '0; bus.adc_ch2_i = '0;
    bus.lia_done_i = 1'b0; bus.lia_x_i = '0; bus.lia_y_i = '0;
    step(); step();
    checks++; if (bus.lia_reset_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_lia_reset got=%0b want=1", bus.lia_reset_o); end
    checks++; if ({bus.lia_tick_o, bus.valid_o, busy_o, overrun_o, timeout_o} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b want=00000", {bus.lia_tick_o, bus.valid_o, busy_o, overrun_o, timeout_o}); end
    checks++; if ({bus.x_o, bus.y_o, bus.lia_ch1_o, bus.lia_ch2_o} !== 96'd0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", {bus.x_o, bus.y_o, bus.lia_ch1_o, bus.lia_ch2_o}); end
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.lia_reset_o !== 1'b1 || busy_o !== 1'b0 || bus.lia_tick_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_cycle%0d got lia_reset=%0b busy=%0b tick=%0b want 1 0 0", i, bus.lia_reset_o, busy_o, bus.lia_tick_o); end
    end
    step();
    checks++; if (bus.lia_reset_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_end got=%0b want=0", bus.lia_reset_o); end
  endtask

  task automatic test_basic();
    decim_i = 16'd1;
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h000100; bus.adc_ch2_i = 24'hFFFF00;
    step();
    bus.adc_valid_i = 1'b0;
    checks++; if (bus.lia_tick_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_tick got tick=%0b busy=%0b want 1 1", bus.lia_tick_o, busy_o); end
    checks++; if (bus.lia_ch1_o !== 24'h000100 || bus.lia_ch2_o !== 24'hFFFF00) begin failures++; $display("[TB] FAIL basic_latch got=%h/%h want=000100/ffff00", bus.lia_ch1_o, bus.lia_ch2_o); end
    step();
    checks++; if (bus.lia_tick_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_tick_width got=%0b want=0", bus.lia_tick_o); end
    step(); step();
    bus.lia_done_i = 1'b1; bus.lia_x_i = 24'h123456; bus.lia_y_i = 24'hFEDCBA;
    step();
    bus.lia_done_i = 1'b0; bus.lia_x_i = 24'h0; bus.lia_y_i = 24'h0;
    checks++; if (bus.valid_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid got valid=%0b busy=%0b want 1 0", bus.valid_o, busy_o); end
    checks++; if (bus.x_o !== 24'h123456 || bus.y_o !== 24'hFEDCBA) begin failures++; $display("[TB] FAIL basic_result got=%h/%h want=123456/fedcba", bus.x_o, bus.y_o); end
    step();
    checks++; if (bus.valid_o !== 1'b0 || bus.x_o !== 24'h123456) begin failures++; $display("[TB] FAIL basic_hold got valid=%0b x=%h want 0 123456", bus.valid_o, bus.x_o); end
  endtask

  task automatic test_decimation();
    logic        v;
    logic [23:0] gx, gy;
    logic [23:0] seen [3];
    int          pulses = 0;
    decim_i = 16'd4;
    for (int k = 1; k <= 12; k++) begin
      send_sample(24'(k), 24'(k + 100), 24'(k * 17), 24'(k * 3), 2, v, gx, gy);
      if (v === 1'b1) begin
        if (pulses < 3) seen[pulses] = gx;
        pulses++;
      end
    end
    checks++; if (pulses != 3) begin failures++; $display("[TB] FAIL decim4_pulses got=%0d want=3", pulses); end
    checks++; if (seen[0] !== 24'd68 || seen[1] !== 24'd136 || seen[2] !== 24'd204) begin failures++; $display("[TB] FAIL decim4_values got=%0d,%0d,%0d want=68,136,204", seen[0], seen[1], seen[2]); end
    decim_i = 16'd0;
    for (int k = 0; k < 2; k++) begin
      send_sample(24'h5, 24'h6, 24'(24'h700 + k), 24'h8, 1, v, gx, gy);
      checks++; if (v !== 1'b1 || gx !== 24'(24'h700 + k)) begin failures++; $display("[TB] FAIL decim0_sample%0d got valid=%0b x=%h want 1 %h", k, v, gx, 24'(24'h700 + k)); end
    end
  endtask

  task automatic test_overrun();
    decim_i = 16'd1;
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h111111; bus.adc_ch2_i = 24'h111111;
    step();
    bus.adc_valid_i = 1'b0;
    step();
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h222222;
    step();
    bus.adc_valid_i = 1'b0;
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got=%0b want=1", overrun_o); end
    checks++; if (bus.lia_ch1_o !== 24'h111111 || bus.lia_tick_o !== 1'b0) begin failures++; $display("[TB] FAIL overrun_not_fwd got ch1=%h tick=%0b want 111111 0", bus.lia_ch1_o, bus.lia_tick_o); end
    bus.lia_done_i = 1'b1;
    step();
    bus.lia_done_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL overrun_clear got=%0b want=0", overrun_o); end

    // done and a new sample in the same cycle
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h333333;
    step();
    bus.adc_valid_i = 1'b0;
    step(); step();
    bus.lia_done_i = 1'b1; bus.lia_x_i = 24'h0A0A0A;
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h444444;
    step();
    bus.lia_done_i = 1'b0; bus.adc_valid_i = 1'b0;
    checks++; if (bus.lia_tick_o !== 1'b1 || bus.valid_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("[TB] FAIL sameCycle_tick got tick=%0b valid=%0b busy=%0b want 1 1 1", bus.lia_tick_o, bus.valid_o, busy_o); end
    checks++; if (bus.lia_ch1_o !== 24'h444444 || overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL sameCycle_latch got ch1=%h overrun=%0b want 444444 0", bus.lia_ch1_o, overrun_o); end
    step();
    bus.adc_valid_i = 1'b1;
    step();
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL overrun_again got=%0b want=1", overrun_o); end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0; bus.adc_valid_i = 1'b0;
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL clear_vs_set got=%0b want=1", overrun_o); end
    bus.lia_done_i = 1'b1;
    step();
    bus.lia_done_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL overrun_clear2 got=%0b want=0", overrun_o); end
  endtask

  task automatic test_timeout();
    logic        v;
    logic [23:0] gx, gy;
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h555555;
    step();
    bus.adc_valid_i = 1'b0;
    for (int i = 0; i < 64; i++) step();
    checks++; if (timeout_o !== 1'b0 || bus.lia_reset_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early got timeout=%0b lia_reset=%0b want 0 0", timeout_o, bus.lia_reset_o); end
    step();
    checks++; if (timeout_o !== 1'b1 || bus.lia_reset_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_set got timeout=%0b lia_reset=%0b busy=%0b want 1 1 0", timeout_o, bus.lia_reset_o, busy_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.lia_reset_o !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flush%0d got=%0b want=1", i, bus.lia_reset_o); end
    end
    step();
    checks++; if (bus.lia_reset_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_flush_end got=%0b want=0", bus.lia_reset_o); end
    send_sample(24'h1, 24'h2, 24'h00BEEF, 24'h00CAFE, 3, v, gx, gy);
    checks++; if (v !== 1'b1 || gx !== 24'h00BEEF || gy !== 24'h00CAFE) begin failures++; $display("[TB] FAIL timeout_recover got valid=%0b x=%h y=%h want 1 00beef 00cafe", v, gx, gy); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("[TB] FAIL timeout_sticky got=%0b want=1", timeout_o); end
  endtask

  task automatic test_disable();
    bus.adc_valid_i = 1'b1; bus.adc_ch1_i = 24'h666666;
    step();
    bus.adc_valid_i = 1'b0;
    step();
    enable_i = 1'b0;
    step();
    checks++; if (bus.lia_reset_o !== 1'b1 || busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL disable_idle got lia_reset=%0b busy=%0b valid=%0b want 1 0 0", bus.lia_reset_o, busy_o, bus.valid_o); end
    bus.lia_done_i = 1'b1; bus.lia_x_i = 24'hABCDEF;
    step();
    bus.lia_done_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0 || bus.x_o !== 24'h00BEEF) begin failures++; $display("[TB] FAIL disable_discard got valid=%0b x=%h want 0 00beef", bus.valid_o, bus.x_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_overrun();
    test_timeout();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
